// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control pipeline.
//   - bundle widths and field bit indices for the WB, MEM and EX control bundles
//   - ALUOp encodings
//   - pipeline register layouts and their bubble (all-zero) constants
package ctrl_pkg;

  localparam int unsigned WB_W  = 2;
  localparam int unsigned MEM_W = 2;
  localparam int unsigned EX_W  = 4;
  localparam int unsigned REG_W = 5;

  // WB = {RegWrite, MemToReg}
  localparam int unsigned WB_REGWRITE  = 1;
  localparam int unsigned WB_MEMTOREG  = 0;
  // MEM = {MemRead, MemWrite}
  localparam int unsigned MEM_MEMREAD  = 1;
  localparam int unsigned MEM_MEMWRITE = 0;
  // EX = {RegDest, ALUOp[1:0], ALUSrc}
  localparam int unsigned EX_REGDEST   = 3;
  localparam int unsigned EX_ALUOP_HI  = 2;
  localparam int unsigned EX_ALUOP_LO  = 1;
  localparam int unsigned EX_ALUSRC    = 0;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [EX_W-1:0]  ex;
    logic             branch;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [REG_W-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] dst;
  } memwb_t;

  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// hazard_unit: combinational load-use / branch / jump resolution.
// Inputs : ID/EX state (valid, MemRead, branch, rt), ID stage (valid, jump,
//          rs, rt) and the EX ALU zero flag.
// Outputs: ifid_hold, ifid_flush, pc_sel_branch toward fetch, and
//          idex_bubble telling the ID/EX register to load a bubble.
module hazard_unit
  import ctrl_pkg::*;
(
  input  logic             idex_valid,
  input  logic             idex_mem_read,
  input  logic             idex_branch,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             id_valid,
  input  logic             id_jump,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_zero,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             pc_sel_branch,
  output logic             idex_bubble
);

  logic load_use;
  logic branch_taken;

  always_comb begin
    load_use = idex_valid && idex_mem_read && (idex_rt != '0) && id_valid &&
               !id_jump && ((idex_rt == id_rs) || (idex_rt == id_rt));
    branch_taken = idex_valid && idex_branch && ex_zero;

    // A taken branch squashes the ID instruction, so holding it is pointless.
    ifid_hold     = load_use && !branch_taken;
    ifid_flush    = branch_taken || (id_valid && id_jump);
    pc_sel_branch = branch_taken;
    idex_bubble   = load_use || branch_taken;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control bundles through ID/EX, EX/MEM and MEM/WB,
// inserts load-use bubbles, turns taken branches and jumps into fetch flushes,
// and counts stall and flush events with saturating counters.
// Inputs : id_* decoded bundle and register fields, ex_zero from the ALU.
// Outputs: ex_*/mem_*/wb_* stage controls (gated by stage valid),
//          ifid_hold/ifid_flush/pc_sel_branch to fetch, stall_cnt/flush_cnt.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [1:0]       id_WB,
  input  logic [1:0]       id_MEM,
  input  logic [3:0]       id_EX,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             ex_zero,
  output logic             ex_RegDest,
  output logic             ex_ALUSrc,
  output logic [1:0]       ex_ALUOp,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic [4:0]       mem_dst,
  output logic             wb_RegWrite,
  output logic             wb_MemToReg,
  output logic [4:0]       wb_dst,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             pc_sel_branch,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  idex_t            idex_q,  idex_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             idex_bubble;
  logic [REG_W-1:0] ex_dst;

  hazard_unit u_hazard (
    .idex_valid    (idex_q.valid),
    .idex_mem_read (idex_q.mem[MEM_MEMREAD]),
    .idex_branch   (idex_q.branch),
    .idex_rt       (idex_q.rt),
    .id_valid      (id_valid),
    .id_jump       (id_jump),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_zero       (ex_zero),
    .ifid_hold     (ifid_hold),
    .ifid_flush    (ifid_flush),
    .pc_sel_branch (pc_sel_branch),
    .idex_bubble   (idex_bubble)
  );

  always_comb begin
    ex_dst = idex_q.ex[EX_REGDEST] ? idex_q.rd : idex_q.rt;

    idex_d = IDEX_BUBBLE;
    if (id_valid && !idex_bubble) begin
      idex_d.valid  = 1'b1;
      idex_d.wb     = id_WB;
      idex_d.mem    = id_MEM;
      idex_d.ex     = id_EX;
      idex_d.branch = id_branch;
      idex_d.rs     = id_rs;
      idex_d.rt     = id_rt;
      idex_d.rd     = id_rd;
    end

    exmem_d = EXMEM_BUBBLE;
    if (idex_q.valid) begin
      exmem_d.valid = 1'b1;
      exmem_d.wb    = idex_q.wb;
      exmem_d.mem   = idex_q.mem;
      exmem_d.dst   = ex_dst;
    end

    memwb_d = MEMWB_BUBBLE;
    if (exmem_q.valid) begin
      memwb_d.valid = 1'b1;
      memwb_d.wb    = exmem_q.wb;
      memwb_d.dst   = exmem_q.dst;
    end

    stall_cnt_d = stall_cnt_q;
    if (ifid_hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q      <= IDEX_BUBBLE;
      exmem_q     <= EXMEM_BUBBLE;
      memwb_q     <= MEMWB_BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    ex_RegDest   = idex_q.valid && idex_q.ex[EX_REGDEST];
    ex_ALUSrc    = idex_q.valid && idex_q.ex[EX_ALUSRC];
    ex_ALUOp     = idex_q.valid ? idex_q.ex[EX_ALUOP_HI:EX_ALUOP_LO] : ALU_ADD;
    ex_rs        = idex_q.rs;
    ex_rt        = idex_q.rt;
    mem_MemRead  = exmem_q.valid && exmem_q.mem[MEM_MEMREAD];
    mem_MemWrite = exmem_q.valid && exmem_q.mem[MEM_MEMWRITE];
    mem_dst      = exmem_q.dst;
    // Writes to $0 are dropped here so the register file never sees them.
    wb_RegWrite  = memwb_q.valid && memwb_q.wb[WB_REGWRITE] && (memwb_q.dst != '0);
    wb_MemToReg  = memwb_q.valid && memwb_q.wb[WB_MEMTOREG];
    wb_dst       = memwb_q.dst;
    stall_cnt    = stall_cnt_q;
    flush_cnt    = flush_cnt_q;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

  localparam int unsigned CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_branch, id_jump, ex_zero;
  logic [1:0]    id_WB, id_MEM;
  logic [3:0]    id_EX;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          ex_RegDest, ex_ALUSrc, mem_MemRead, mem_MemWrite;
  logic          wb_RegWrite, wb_MemToReg, ifid_hold, ifid_flush, pc_sel_branch;
  logic [1:0]    ex_ALUOp;
  logic [4:0]    ex_rs, ex_rt, mem_dst, wb_dst;
  logic [CW-1:0] stall_cnt, flush_cnt;

  ctrl_pipe #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_WB(id_WB), .id_MEM(id_MEM),
    .id_EX(id_EX), .id_branch(id_branch), .id_jump(id_jump), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero), .ex_RegDest(ex_RegDest),
    .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_dst(mem_dst),
    .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_dst(wb_dst),
    .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .pc_sel_branch(pc_sel_branch),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An instruction record; occ[k] is what occupies stage k (0=EX, 1=MEM, 2=WB).
  typedef struct {
    bit       v;
    bit [1:0] wb;
    bit [1:0] mem;
    bit [3:0] ex;
    bit       br;
    int       rs, rt, rd;
  } rec_t;

  rec_t occ [0:2];
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic rec_t empty_rec();
    rec_t r;
    r.v = 0; r.wb = 0; r.mem = 0; r.ex = 0; r.br = 0; r.rs = 0; r.rt = 0; r.rd = 0;
    return r;
  endfunction

  function automatic int dst_of(rec_t r);
    if (!r.v) return 0;
    return r.ex[3] ? r.rd : r.rt;
  endfunction

  function automatic bit m_load_use();
    return occ[0].v && occ[0].mem[1] && occ[0].rt != 0 && id_valid && !id_jump &&
           (occ[0].rt == int'(id_rs) || occ[0].rt == int'(id_rt));
  endfunction

  function automatic bit m_taken();
    return occ[0].v && occ[0].br && ex_zero;
  endfunction

  initial for (int k = 0; k < 3; k++) occ[k] = empty_rec();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) occ[k] = empty_rec();
      m_stall = 0;
      m_flush = 0;
    end else begin
      rec_t nr;
      bit lu, bt;
      lu = m_load_use();
      bt = m_taken();
      if (lu && !bt && m_stall < SAT) m_stall++;
      if ((bt || (id_valid && id_jump)) && m_flush < SAT) m_flush++;
      nr = empty_rec();
      if (id_valid && !lu && !bt) begin
        nr.v = 1; nr.wb = id_WB; nr.mem = id_MEM; nr.ex = id_EX; nr.br = id_branch;
        nr.rs = int'(id_rs); nr.rt = int'(id_rt); nr.rd = int'(id_rd);
      end
      occ[2] = occ[1];
      occ[1] = occ[0];
      occ[0] = nr;
    end
  end

  // One compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    bit lu, bt;
    lu = m_load_use();
    bt = m_taken();
    chk("ex_RegDest",   32'(ex_RegDest),   32'(occ[0].v & occ[0].ex[3]));
    chk("ex_ALUSrc",    32'(ex_ALUSrc),    32'(occ[0].v & occ[0].ex[0]));
    chk("ex_ALUOp",     32'(ex_ALUOp),     occ[0].v ? 32'(occ[0].ex[2:1]) : 32'd0);
    chk("ex_rs",        32'(ex_rs),        32'(occ[0].rs));
    chk("ex_rt",        32'(ex_rt),        32'(occ[0].rt));
    chk("mem_MemRead",  32'(mem_MemRead),  32'(occ[1].v & occ[1].mem[1]));
    chk("mem_MemWrite", 32'(mem_MemWrite), 32'(occ[1].v & occ[1].mem[0]));
    chk("mem_dst",      32'(mem_dst),      32'(dst_of(occ[1])));
    chk("wb_RegWrite",  32'(wb_RegWrite),  32'(occ[2].v & occ[2].wb[1] & (dst_of(occ[2]) != 0)));
    chk("wb_MemToReg",  32'(wb_MemToReg),  32'(occ[2].v & occ[2].wb[0]));
    chk("wb_dst",       32'(wb_dst),       32'(dst_of(occ[2])));
    chk("ifid_hold",    32'(ifid_hold),    32'(lu & !bt));
    chk("ifid_flush",   32'(ifid_flush),   32'(bt | (id_valid & id_jump)));
    chk("pc_sel",       32'(pc_sel_branch), 32'(bt));
    chk("stall_cnt",    32'(stall_cnt),    32'(m_stall));
    chk("flush_cnt",    32'(flush_cnt),    32'(m_flush));
  end

  // ---------------- directed stimulus ----------------
  task automatic set_id(input bit v, input bit [1:0] wb, input bit [1:0] mem,
                        input bit [3:0] ex, input bit br, input bit j,
                        input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
    id_valid = v; id_WB = wb; id_MEM = mem; id_EX = ex; id_branch = br;
    id_jump = j; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic idle();
    set_id(0, 2'b00, 2'b00, 4'b0000, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic half();
    @(negedge clk); #1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_zero = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    half();
    chk("rst_ex_aluop", 32'(ex_ALUOp), 0);
    chk("rst_wb_dst", 32'(wb_dst), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    rst_n = 1'b1;
    nxt();

    // R-type straight-line flow
    set_id(1, 2'b10, 2'b00, 4'b1100, 0, 0, 5'd1, 5'd2, 5'd5); half(); nxt();
    idle(); half();
    chk("rt_ex_regdest", 32'(ex_RegDest), 1);
    chk("rt_ex_aluop", 32'(ex_ALUOp), 2);
    nxt();
    half(); chk("rt_mem_dst", 32'(mem_dst), 5); nxt();
    half(); chk("rt_wb_regwrite", 32'(wb_RegWrite), 1); chk("rt_wb_dst", 32'(wb_dst), 5); nxt();

    // load-use: lw rt=8 then add rs=8
    set_id(1, 2'b11, 2'b10, 4'b0001, 0, 0, 5'd1, 5'd8, 5'd0); half(); nxt();
    set_id(1, 2'b10, 2'b00, 4'b1100, 0, 0, 5'd8, 5'd3, 5'd9); half();
    chk("lu_hold", 32'(ifid_hold), 1);
    chk("lu_stall_before", 32'(stall_cnt), 0);
    nxt();
    half();
    chk("lu_hold_drop", 32'(ifid_hold), 0);
    chk("lu_ex_bubble_src", 32'(ex_ALUSrc), 0);
    chk("lu_ex_bubble_rs", 32'(ex_rs), 0);
    chk("lu_stall_after", 32'(stall_cnt), 1);
    nxt();
    idle(); half();
    chk("lu_add_in_ex", 32'(ex_RegDest), 1);
    chk("lu_add_rs", 32'(ex_rs), 8);
    nxt();

    // taken branch
    set_id(1, 2'b00, 2'b00, 4'b0010, 1, 0, 5'd1, 5'd2, 5'd0); half(); nxt();
    set_id(1, 2'b10, 2'b00, 4'b0001, 0, 0, 5'd3, 5'd4, 5'd0); ex_zero = 1'b1; half();
    chk("br_pcsel", 32'(pc_sel_branch), 1);
    chk("br_flush", 32'(ifid_flush), 1);
    chk("br_flush_cnt_before", 32'(flush_cnt), 0);
    nxt();
    idle(); ex_zero = 1'b0; half();
    chk("br_ex_squashed", 32'(ex_ALUSrc), 0);
    chk("br_ex_aluop", 32'(ex_ALUOp), 0);
    chk("br_flush_cnt_after", 32'(flush_cnt), 1);
    nxt();

    // not-taken branch
    set_id(1, 2'b00, 2'b00, 4'b0010, 1, 0, 5'd1, 5'd2, 5'd0); half(); nxt();
    set_id(1, 2'b10, 2'b00, 4'b0001, 0, 0, 5'd3, 5'd4, 5'd0); half();
    chk("nt_flush", 32'(ifid_flush), 0);
    chk("nt_pcsel", 32'(pc_sel_branch), 0);
    nxt();
    idle(); half(); chk("nt_addi_in_ex", 32'(ex_ALUSrc), 1); nxt();

    // taken branch and load-use together
    set_id(1, 2'b00, 2'b10, 4'b0010, 1, 0, 5'd1, 5'd8, 5'd0); half(); nxt();
    set_id(1, 2'b10, 2'b00, 4'b1100, 0, 0, 5'd8, 5'd3, 5'd9); ex_zero = 1'b1; half();
    chk("both_hold", 32'(ifid_hold), 0);
    chk("both_flush", 32'(ifid_flush), 1);
    nxt();
    idle(); ex_zero = 1'b0; half();
    chk("both_stall_unchanged", 32'(stall_cnt), 1);
    chk("both_flush_cnt", 32'(flush_cnt), 2);
    nxt();

    // addi with rt=0: write suppressed
    set_id(1, 2'b10, 2'b00, 4'b0001, 0, 0, 5'd3, 5'd0, 5'd0); half(); nxt();
    idle(); half(); nxt();
    half(); nxt();
    half(); chk("zero_dst_regwrite", 32'(wb_RegWrite), 0); nxt();

    // jump in ID
    set_id(1, 2'b00, 2'b00, 4'b0000, 0, 1, 5'd0, 5'd0, 5'd0); half();
    chk("jmp_flush", 32'(ifid_flush), 1);
    nxt();
    idle(); half(); chk("jmp_flush_cnt", 32'(flush_cnt), 3); nxt();
    half(); nxt();
    half(); chk("jmp_no_write", 32'(wb_RegWrite), 0); nxt();

    // jump whose rs field matches a load in EX must not stall
    set_id(1, 2'b11, 2'b10, 4'b0001, 0, 0, 5'd1, 5'd8, 5'd0); half(); nxt();
    set_id(1, 2'b00, 2'b00, 4'b0000, 0, 1, 5'd8, 5'd8, 5'd0); half();
    chk("jmp_lu_hold", 32'(ifid_hold), 0);
    nxt();
    idle(); half(); nxt();

    // drive stall_cnt into saturation
    for (int i = 0; i < 17; i++) begin
      set_id(1, 2'b11, 2'b10, 4'b0001, 0, 0, 5'd1, 5'd8, 5'd0); half(); nxt();
      set_id(1, 2'b10, 2'b00, 4'b1100, 0, 0, 5'd8, 5'd8, 5'd9); half(); nxt();
      half(); nxt();
    end
    idle(); half();
    chk("stall_saturated", 32'(stall_cnt), SAT);
    nxt();

    // reset asserted mid-pipeline
    set_id(1, 2'b10, 2'b00, 4'b1100, 0, 0, 5'd1, 5'd2, 5'd5); half(); nxt();
    set_id(1, 2'b11, 2'b10, 4'b0001, 0, 0, 5'd1, 5'd6, 5'd0); half();
    rst_n = 1'b0; #1;
    chk("rst_async_ex", 32'(ex_RegDest), 0);
    chk("rst_async_mem", 32'(mem_dst), 0);
    chk("rst_async_stall", 32'(stall_cnt), 0);
    chk("rst_async_flush", 32'(flush_cnt), 0);
    idle(); nxt();
    half(); rst_n = 1'b1; nxt();
    set_id(1, 2'b10, 2'b00, 4'b1100, 0, 0, 5'd1, 5'd2, 5'd7); half();
    chk("post_rst_first_cycle", 32'(ex_RegDest), 0);
    nxt();
    idle(); half(); chk("post_rst_ex", 32'(ex_RegDest), 1); nxt();
    half(); chk("post_rst_mem_dst", 32'(mem_dst), 7); nxt();
    half(); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control bundles (WB, MEM, EX, branch, jump) from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers. Delivers each bundle's fields to the stage that consumes them. Detects load-use hazards and inserts bubbles. Turns taken branches and jumps into flush requests toward fetch. Sits between the control decoder and the EX/MEM/WB datapath.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  the ID stage holds a real instruction
- id_WB  in  2  {RegWrite, MemToReg}
- id_MEM  in  2  {MemRead, MemWrite}
- id_EX  in  4  {RegDest, ALUOp[1:0], ALUSrc}
- id_branch  in  1  beq decoded
- id_jump  in  1  j decoded
- id_rs, id_rt, id_rd  in  5 each  register fields of the instruction in ID
- ex_zero  in  1  ALU zero flag of the instruction currently in EX
- ex_RegDest, ex_ALUSrc  out  1  EX controls
- ex_ALUOp  out  2  EX control
- ex_rs, ex_rt  out  5  registered ID/EX source fields
- mem_MemRead, mem_MemWrite  out  1  MEM controls
- mem_dst  out  5  destination register in MEM
- wb_RegWrite, wb_MemToReg  out  1  WB controls
- wb_dst  out  5  destination register in WB
- ifid_hold  out  1  hold the PC and the IF/ID register this cycle
- ifid_flush  out  1  zero the IF/ID register at the next edge
- pc_sel_branch  out  1  fetch takes the branch target
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- ID/EX register holds {valid, WB, MEM, EX, branch, rs, rt, rd}.
- EX/MEM register holds {valid, WB, MEM, dst}.
- MEM/WB register holds {valid, WB, dst}.
- dst is computed in EX: ex_RegDest ? ex_rd : ex_rt.
- A bubble means valid=0 with all control bits 0. Stage control outputs are gated by that stage's valid bit.
- Load-use hazard, combinational:
  - Condition: ID/EX.valid & ID/EX.MemRead & ex_rt≠0 & id_valid & !id_jump & (ex_rt==id_rs | ex_rt==id_rt).
  - Response: ifid_hold=1 and a bubble is loaded into ID/EX. EX/MEM and MEM/WB advance normally.
- Branch taken, combinational:
  - Condition: ID/EX.valid & ID/EX.branch & ex_zero.
  - Response: pc_sel_branch=1 and ifid_flush=1. ID/EX loads a bubble, killing the instruction in ID.
- Jump: id_valid & id_jump → ifid_flush=1, which kills the slot fetched after the jump. The jump itself enters ID/EX carrying its all-zero writes.
- Priority: branch-taken over load-use. When both are true, ifid_hold=0, because the ID instruction is squashed anyway.
- If a taken branch and a jump in ID occur together, the branch wins. The jump is squashed by the ID/EX bubble, and ifid_flush is still 1.
- wb_RegWrite is forced to 0 when wb_dst==0. Writes to $0 are suppressed.
- stall_cnt increments on every cycle with ifid_hold=1. flush_cnt increments on every cycle with ifid_flush=1. Both saturate at all-ones and never wrap.

## Timing
- All pipeline registers update on the rising edge of clk.
- Reset: all valid bits, control bits, register fields and counters clear to 0 asynchronously. All registered outputs read 0 during reset and on the first cycle after release.
- Latency: a bundle presented at ID in cycle N appears:
  - on the ex_* outputs in cycle N+1
  - on the mem_* outputs in cycle N+2
  - on the wb_* outputs in cycle N+3
- ifid_hold, ifid_flush and pc_sel_branch are combinational from the current register state and the id_* inputs. They have no registered delay.
- A load-use stall lasts exactly one cycle. In the next cycle ID/EX holds a bubble, so the hazard condition drops.
- Reset asserted mid-stall or mid-flush aborts it immediately. No pending state survives reset.

## Structure
- Shared package `ctrl_pkg` holds:
  - bundle widths (WB_W=2, MEM_W=2, EX_W=4)
  - field bit indices: WB={RegWrite,MemToReg}, MEM={MemRead,MemWrite}, EX={RegDest,ALUOp,ALUSrc}
  - ALUOp codes: 00 add, 01 sub, 10 funct
  - the bubble constant
- One sub-module, `hazard_unit`, is combinational. It takes the ID/EX state plus id_rs, id_rt, id_valid, id_jump and ex_zero, and produces ifid_hold, ifid_flush, pc_sel_branch and the ID/EX bubble select.
- The pipeline registers and counters live in `ctrl_pipe`.

## Test plan
- Straight-line flow: an R-type bundle (WB=10, MEM=00, EX=1100, rd=5) at cycle 0 → ex_RegDest=1 and ex_ALUOp=10 at cycle 1; mem_dst=5 at cycle 2; wb_RegWrite=1 and wb_dst=5 at cycle 3.
- Load-use: lw rt=8, followed by add rs=8 → ifid_hold=1 for one cycle, EX shows a bubble, stall_cnt=1. The add reaches EX one cycle later.
- Taken branch: beq in EX with ex_zero=1 → pc_sel_branch=1 and ifid_flush=1 in the same cycle. Next cycle the ex_* controls are 0 and flush_cnt=1. With ex_zero=0: no flush.
- Simultaneous events: taken branch plus load-use in the same cycle → ifid_hold=0, ifid_flush=1, stall_cnt unchanged.
- $0 destination: addi with rt=0 → wb_RegWrite=0 at cycle 3. Jump in ID → ifid_flush=1 and no register write.
- Reset and saturation:
  - Force stall_cnt to all-ones → it holds at all-ones.
  - Assert rst_n=0 mid-pipeline → all outputs are 0 immediately, and the first id bundle after release emerges on cycle +1.
